// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: issue opcodes and controller states.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes; one quotient bit per cycle.
// The first bit is resolved on the start edge, so done is high WIDTH-1 edges later.
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_in, quo_in, dsr_in, rem_next, quo_next;
    logic [WIDTH:0]   shifted, trial;

    always_comb begin
        rem_in  = start ? '0       : rem_q;
        quo_in  = start ? dividend : quo_q;
        dsr_in  = start ? divisor  : dsr_q;
        shifted = {rem_in, quo_in[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_in};
        // A clear borrow bit means the divisor fits: keep the difference.
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo_in[WIDTH-2:0], 1'b0};
        end

        rem_d = rem_q;
        quo_d = quo_q;
        dsr_d = dsr_q;
        cnt_d = cnt_q;
        if (start) begin
            rem_d = rem_next;
            quo_d = quo_next;
            dsr_d = dsr_in;
            cnt_d = CW'(WIDTH - 1);
        end else if (cnt_q != '0) begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = (cnt_q == '0);

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit writing HI/LO, plus MTHI/MTLO; busy stalls MD-class issue.
// Only IDLE accepts a new operation; a divide completes when both DIV_LAT and the divider are done.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;
    logic               busy_q, busy_d;

    logic               op_signed, a_neg, b_neg, div_start, div_done;
    logic [WIDTH-1:0]   a_mag, b_mag, div_quo, div_rem, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] ext_a, ext_b;

    assign op        = mdu_op_e'(mdu_op);
    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign a_neg     = op_signed & src_a[WIDTH-1];
    assign b_neg     = op_signed & src_b[WIDTH-1];
    assign a_mag     = a_neg ? -src_a : src_a;
    assign b_mag     = b_neg ? -src_b : src_b;
    // Sign- or zero-extension makes one 2*WIDTH multiply serve both MULT and MULTU.
    assign ext_a     = {{WIDTH{a_neg}}, src_a};
    assign ext_b     = {{WIDTH{b_neg}}, src_b};
    assign quo_fix   = q_neg_q ? -div_quo : div_quo;
    assign rem_fix   = r_neg_q ? -div_rem : div_rem;

    mdu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod_d    = prod_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dz_d      = dz_q;
        div_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            prod_d  = ext_a * ext_b;
                            cnt_d   = MUL_CNT;
                            state_d = ST_MUL;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            div_start = 1'b1;
                            q_neg_d   = a_neg ^ b_neg;
                            r_neg_d   = a_neg;
                            dz_d      = (src_b == '0);
                            cnt_d     = DIV_CNT;
                            state_d   = ST_DIV;
                        end
                        MDU_MTHI: hi_d = src_a;
                        MDU_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    {hi_d, lo_d} = prod_q;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DIV: begin
                // The counter parks at one until the divider catches up.
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    if (div_done) begin
                        if (!dz_q) begin
                            lo_d = quo_fix;
                            hi_d = rem_fix;
                        end
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Busy rises one edge after issue and drops on the completing or cancelling edge.
        busy_d = (state_q != ST_IDLE) && (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus queues {busy,hi,lo} expected after a given edge,
// and a negedge monitor pops and compares each entry when that edge has passed.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] src_a, src_b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi, lo;

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    mdu_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc equals N during the cycle that follows rising edge N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got busy=%b hi=%h lo=%h, expected busy=%b hi=%h lo=%h",
                     name, act[64], act[63:32], act[31:0], req[64], req[63:32], req[31:0]);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, {busy, hi, lo}, {e.busy, e.hi, e.lo});
        end
    end

    task automatic push(input int due, input logic [31:0] h, input logic [31:0] l,
                        input logic b, input string name);
        exp_t e;
        e.due  = due;
        e.hi   = h;
        e.lo   = l;
        e.busy = b;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Drives a start strobe that the next rising edge (returned as n) samples.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        src_a  = a;
        src_b  = b;
        n      = cyc + 1;
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int n;
        int c;
        reset  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        mdu_op = 3'd0;
        src_a  = '0;
        src_b  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        push(cyc + 1, 32'h0, 32'h0, 1'b0, "reset_state");

        // Signed multiply -2 * 3
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, n);
        push(n,     32'h0, 32'h0, 1'b0, "mult_busy_issue_edge");
        push(n + 1, 32'h0, 32'h0, 1'b1, "mult_busy_rise");
        push(n + 4, 32'h0, 32'h0, 1'b1, "mult_busy_last");
        push(n + 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult_result");
        drop_start();
        wait_until(n + 6);

        // Unsigned multiply 0xFFFFFFFF * 2
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, n);
        push(n + 4, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, "multu_pending");
        push(n + 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, "multu_result");
        drop_start();
        wait_until(n + 6);

        // Signed divide -7 / 2: divider needs 32 cycles, longer than DIV_LAT
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
        push(n + 9,  32'h0000_0001, 32'hFFFF_FFFE, 1'b1, "div_not_at_div_lat");
        push(n + 31, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, "div_pending");
        push(n + 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_result");
        drop_start();
        wait_until(n + 33);

        // Unsigned divide by zero leaves HI/LO alone with normal timing
        issue(MDU_DIVU, 32'd7, 32'd0, n);
        push(n + 31, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, "divz_pending");
        push(n + 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "divz_unchanged");
        drop_start();
        wait_until(n + 33);

        // MTHI while idle
        issue(MDU_MTHI, 32'h1234_5678, 32'd0, n);
        push(n, 32'h1234_5678, 32'hFFFF_FFFD, 1'b0, "mthi_write");
        drop_start();
        wait_until(n + 1);

        // Invalid opcode is ignored
        issue(3'd7, 32'hAAAA_AAAA, 32'h5555_5555, n);
        push(n,     32'h1234_5678, 32'hFFFF_FFFD, 1'b0, "invalid_op_issue");
        push(n + 1, 32'h1234_5678, 32'hFFFF_FFFD, 1'b0, "invalid_op_after");
        drop_start();
        wait_until(n + 2);

        // MTLO while busy is ignored
        issue(MDU_MULTU, 32'd3, 32'd5, n);
        push(n + 3, 32'h1234_5678, 32'hFFFF_FFFD, 1'b1, "mtlo_while_busy");
        push(n + 5, 32'h0000_0000, 32'h0000_000F, 1'b0, "multu_3x5");
        drop_start();
        @(negedge clk);
        start  = 1'b1;
        mdu_op = MDU_MTLO;
        src_a  = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        wait_until(n + 6);

        // Signed overflow MIN_INT / -1
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        push(n + 31, 32'h0000_0000, 32'h0000_000F, 1'b1, "ovf_pending");
        push(n + 32, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_overflow");
        drop_start();
        wait_until(n + 33);

        // Cancel a running multiply on its second cycle
        issue(MDU_MULT, 32'd7, 32'd7, n);
        push(n + 1, 32'h0, 32'h8000_0000, 1'b1, "cancel_before");
        push(n + 2, 32'h0, 32'h8000_0000, 1'b0, "cancel_busy_drop");
        push(n + 6, 32'h0, 32'h8000_0000, 1'b0, "cancel_no_write");
        drop_start();
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        wait_until(n + 7);

        // Cancel together with start in IDLE wins
        issue(MDU_MTHI, 32'h5555_5555, 32'd0, n);
        cancel = 1'b1;
        push(n, 32'h0, 32'h8000_0000, 1'b0, "cancel_beats_start");
        drop_start();
        cancel = 1'b0;
        wait_until(n + 1);

        // Asynchronous reset in the middle of a divide
        issue(MDU_DIV, 32'd100, 32'd7, n);
        push(n + 3, 32'h0, 32'h8000_0000, 1'b1, "div_before_reset");
        drop_start();
        wait_until(n + 5);
        #2 reset = 1'b0;
        #1 check("reset_async", {busy, hi, lo}, 65'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        c = cyc;
        push(c + 1,  32'h0, 32'h0, 1'b0, "post_reset_idle");
        push(c + 35, 32'h0, 32'h0, 1'b0, "no_stale_div");
        wait_until(c + 36);

        issue(MDU_MULT, 32'd3, 32'd4, n);
        push(n + 5, 32'h0, 32'd12, 1'b0, "mult_after_reset");
        drop_start();

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expected entries still pending, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
